// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant encoding, wait-counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_I,
    GRANT_D
  } grant_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the MIPS fetch/data ports, the arbiter and the single-port memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester raises req with stable addr/data and holds them until
  // its one-cycle ack; rdata is meaningful only in the ack cycle and 0 otherwise.
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select. MEM_ARB_RR_EN switches the both-requesting case
// from fixed data-over-fetch priority to round-robin against last_grant.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  grant_t     last_grant,
  input  logic [1:0] excl,       // [0] masks fetch, [1] masks data
  output grant_t     grant
);

  logic i_ok;
  logic d_ok;

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_comb begin
    i_ok  = i_req & ~excl[0];
    d_ok  = d_req & ~excl[1];
    grant = GRANT_NONE;
    if (i_ok && d_ok) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
`else
      grant = GRANT_D;
`endif
    end else if (d_ok) begin
      grant = GRANT_D;
    end else if (i_ok) begin
      grant = GRANT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises MIPS fetch and data requests onto one single-port memory with
// configurable wait states. Optional round-robin arbitration: MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus,
  output state_t         dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  grant_t            grant_q, grant_d;
  grant_t            last_q, last_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d;

  logic [1:0]        excl;
  grant_t            pick_g;

  // In DONE the just-acked requester still holds req high, so mask it out.
  always_comb begin
    excl = 2'b00;
    if (state_q == DONE) begin
      excl = {grant_q == GRANT_D, grant_q == GRANT_I};
    end
  end

  mem_arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_q),
    .excl       (excl),
    .grant      (pick_g)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;

    case (state_q)
      IDLE: begin
        if (pick_g != GRANT_NONE) begin
          state_d = ISSUE;
          grant_d = pick_g;
        end
      end
      ISSUE: begin
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      DONE: begin
        last_d = grant_q;
        if (pick_g != GRANT_NONE) begin
          state_d = ISSUE;
          grant_d = pick_g;
        end else begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase

    // Capture the winner's request whenever a new transaction starts.
    if ((state_q == IDLE || state_q == DONE) && pick_g == GRANT_D) begin
      addr_d  = bus.d_addr;
      we_d    = bus.d_we;
      wdata_d = bus.d_wdata;
    end else if ((state_q == IDLE || state_q == DONE) && pick_g == GRANT_I) begin
      addr_d  = bus.i_addr;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= GRANT_NONE;
      last_q  <= GRANT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign bus.m_en    = (state_q == ISSUE);
  assign bus.m_we    = (state_q == ISSUE) & we_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.i_ack   = (state_q == DONE) && (grant_q == GRANT_I);
  assign bus.d_ack   = (state_q == DONE) && (grant_q == GRANT_D);
  assign bus.i_rdata = bus.i_ack ? bus.m_rdata : '0;
  assign bus.d_rdata = bus.d_ack ? bus.m_rdata : '0;
  assign dbg_state   = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous unified memory between the MIPS instruction-fetch port and data port.
- Serialises requests through a 4-state FSM, applies the configured wait states, and returns a one-cycle ack with read data to the winning requester.
- Sits between `mips` and the unified memory; the core holds its stall while a request is pending without ack.

Parameters:
- AW, 32, address width of both requesters and the memory.
- DW, 32, data width.
- WAIT_STATES, 0, extra memory cycles after the issue cycle before read data is valid (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held high until i_ack.
- i_addr  in  AW  fetch byte address.
- i_ack  out  1  one-cycle completion pulse for fetch.
- i_rdata  out  DW  fetched word; valid only while i_ack=1, else 0.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DW  load word; valid only while d_ack=1, else 0.
- m_en  out  1  memory access strobe, one cycle per transaction.
- m_we  out  1  memory write enable; high only when m_en=1.
- m_addr  out  AW  latched address.
- m_wdata  out  DW  latched write data.
- m_rdata  in  DW  memory read data, valid 1+WAIT_STATES cycles after the m_en cycle.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (async, reset=0):
  - FSM goes to IDLE; wait counter=0; grant=NONE; last_grant=INSTR.
  - All outputs 0, including m_en, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata and d_rdata.
  - Any in-flight transaction is abandoned, with no ack.
- IDLE:
  - If either request is high, select a winner by the arbitration rule.
  - Latch the winner's address, plus we/wdata for data; a fetch forces we=0.
  - Set grant and go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - m_en=1 for exactly one cycle; m_we=latched we.
  - Go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else go to DONE.
- WAIT: decrement the counter; go to DONE when it reaches 0.
- DONE:
  - Pulse the granted requester's ack for one cycle.
  - Drive its rdata = m_rdata combinationally; for a store, rdata is also driven = m_rdata and is don't-care to the core.
  - Update last_grant.
  - In the same cycle, if the other requester is high, latch it and go to ISSUE (back-to-back, no idle bubble). Otherwise go to IDLE.
  - The just-acked requester is excluded from this selection, because its req is still high during the ack cycle.
- Latency: req sampled in IDLE -> ack 2+WAIT_STATES cycles later. A back-to-back second requester gets its ack 2+WAIT_STATES cycles after the first ack.
- Default arbitration when both requests are high in IDLE: data wins over instruction (fixed priority).
- Requester protocol: req, address and data are stable from assertion until ack; req drops the cycle after ack. A request dropped before ack is protocol violation; the arbiter still completes the access.
- m_addr and m_wdata hold their last latched values between transactions.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: when both requests are high in IDLE, the winner is the requester NOT equal to last_grant (round-robin). After reset last_grant=INSTR, so data wins first.
- Undefined: fixed data-over-instruction priority; last_grant is still maintained but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - grant enum {GRANT_NONE, GRANT_I, GRANT_D};
  - WAIT_W=4 counter-width constant.
- One natural sub-module: mem_arb_pick, a combinational winner select.
  - Inputs: i_req, d_req, last_grant, exclude mask.
  - Output: grant.
  - The only place the MEM_ARB_RR_EN alternative is implemented.

Test Plan:
- Reset mid-ISSUE: d_req=1 with d_addr=0x40, assert reset=0 during the ISSUE cycle -> m_en, d_ack and all outputs are 0 immediately; after release, the arbiter re-arbitrates from IDLE.
- Lone fetch, WAIT_STATES=0: i_req=1, i_addr=0x08, m_rdata=0x20020005 -> m_en pulses 1 cycle later with m_addr=0x08 and m_we=0; i_ack=1 with i_rdata=0x20020005 two cycles after the request; i_rdata=0 on all other cycles.
- Store, WAIT_STATES=3: d_req=1, d_we=1, d_addr=0x54, d_wdata=0x7 -> single m_en cycle with m_we=1, m_addr=0x54, m_wdata=0x7; d_ack 5 cycles after the request; no second m_en.
- Simultaneous requests, fixed priority: i_req=d_req=1 in IDLE:
  - data ISSUE first; d_ack at cycle 2;
  - fetch ISSUE in the DONE cycle; i_ack at cycle 4;
  - exactly two m_en pulses.
- Round-robin (MEM_ARB_RR_EN): three rounds, both requests raised together from IDLE each round -> grant order D, I, D.
- Continuous back-to-back: both reqs re-raised the cycle after each ack for 20 cycles -> acks alternate with no IDLE cycle between transactions; the two acks never coincide.
